// File: rtl/clock_divider_bank_pkg.sv
// Shared constants for the clock-enable divider bank: input clock rate,
// default half-periods for the standard blink rates and a Hz-to-half-period helper.
package clock_divider_bank_pkg;

    localparam int unsigned CLK_HZ     = 50_000_000;

    localparam int unsigned HALF_2HZ   = 12_500_000;
    localparam int unsigned HALF_1HZ   = 25_000_000;
    localparam int unsigned HALF_05HZ  = 50_000_000;
    localparam int unsigned HALF_025HZ = 100_000_000;

    // Half-period in CLK_HZ cycles for a square wave of hz; 0 Hz maps to 0 (an invalid setting).
    function automatic int unsigned half_from_hz(input int unsigned hz);
        return (hz == 0) ? 0 : CLK_HZ / (2 * hz);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: half-period counter, compare, registered square output
// and a registered tick on every rising edge of that output.
module clkdiv_channel #(
    parameter int               CNT_W      = 28,
    parameter logic [CNT_W-1:0] RESET_HALF = CNT_W'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clear,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             wrap;

    // NOTE: every signal gets its hold value first, so no branch can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d     = cnt_q;
        half_d    = half_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        wrap      = (cnt_q == half_q - 1'b1);

        if (load) begin
            half_d    = load_val;
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else if (clear) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt_d     = '0;
                clk_out_d = ~clk_out_q;
                tick_d    = ~clk_out_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments here so every flop samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            half_q    <= RESET_HALF;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of N_CH independently programmable clock-enable generators on CLOCK_50,
// with per-channel half-period writes, a global phase-align strobe and write-error flag.
module clock_divider_bank
    import clock_divider_bank_pkg::*;
#(
    parameter int                    N_CH         = 4,
    parameter int                    CNT_W        = 28,
    parameter logic [N_CH*CNT_W-1:0] DEFAULT_HALF = {28'(HALF_025HZ), 28'(HALF_05HZ),
                                                     28'(HALF_1HZ), 28'(HALF_2HZ)},
    localparam int                   CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [N_CH-1:0]  en,
    input  logic             sync_all,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_half,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic             cfg_err
);

    // One extra bit so N_CH itself is representable when N_CH is a power of two.
    localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

    logic            cfg_ok;
    logic            cfg_err_q, cfg_err_d;
    logic [N_CH-1:0] load;

    always_comb begin
        load      = '0;
        cfg_ok    = cfg_we && (cfg_half != '0) && ({1'b0, cfg_ch} < N_CH_L);
        cfg_err_d = cfg_we && !cfg_ok;
        for (int i = 0; i < N_CH; i++) begin
            load[i] = cfg_ok && (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    // Load outranks clear inside the channel, so write plus sync_all on one channel acts as a write.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clkdiv_channel #(
            .CNT_W      (CNT_W),
            .RESET_HALF (DEFAULT_HALF[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk      (CLOCK_50),
            .reset    (reset),
            .en       (en[i]),
            .load     (load[i]),
            .load_val (cfg_half),
            .clear    (sync_all),
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

endmodule
